dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port data memory (combinational read, write on clk rising edge).
- Shares the memory between the core load/store unit (port C) and the DMA/program-loader port (port D).
- Round-robin arbitration; each access runs through a 3-state FSM.
- Checks alignment, funct3 legality and address range before any write reaches memory.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and 3-state access sequencer sharing one single-port data memory
// between the core load/store port (C) and the DMA/loader port (D).
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [2:0]            c_funct3,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  c_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_funct3,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t                r_state;
    logic                  r_last;
    logic                  r_port;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic w_pick_c;
    logic w_pick_d;
    logic w_idle;
    logic w_access;
    logic w_resp;
    logic w_misalign;
    logic w_bad_f3;
    logic w_bad_store;
    logic w_out_of_range;
    logic w_err;

    // On a tie the port that was not served last wins; the two picks are mutually exclusive.
    assign w_pick_c = c_req & (~d_req | (r_last == PORT_D));
    assign w_pick_d = d_req & (~c_req | (r_last == PORT_C));

    assign w_idle   = (r_state == ST_IDLE)   & ~reset;
    assign w_access = (r_state == ST_ACCESS) & ~reset;
    assign w_resp   = (r_state == ST_RESP)   & ~reset;

    assign c_gnt = w_idle & w_pick_c;
    assign d_gnt = w_idle & w_pick_d;

    assign w_misalign     = ((r_funct3[1:0] == 2'b01) & r_addr[0])
                          | ((r_funct3[1:0] == 2'b10) & (r_addr[1:0] != 2'b00));
    assign w_bad_f3       = (r_funct3 == 3'b011) | (r_funct3 == 3'b110) | (r_funct3 == 3'b111);
    assign w_bad_store    = r_we & r_funct3[2];
    assign w_out_of_range = (r_addr >= ADDR_WIDTH'(MEM_BYTES));
    assign w_err          = w_misalign | w_bad_f3 | w_bad_store | w_out_of_range;

    // Memory sees nothing outside ACCESS, so a reset mid-access kills the write at once.
    assign mem_wr_en   = w_access & r_we & ~w_err;
    assign mem_funct3  = w_access ? r_funct3 : 3'b000;
    assign mem_addr    = w_access ? r_addr   : '0;
    assign mem_wr_data = w_access ? r_wdata  : '0;

    assign c_rvalid = w_resp & (r_port == PORT_C);
    assign d_rvalid = w_resp & (r_port == PORT_D);
    assign c_rdata  = c_rvalid ? r_rdata : '0;
    assign d_rdata  = d_rvalid ? r_rdata : '0;
    assign c_err    = c_rvalid & r_err;
    assign d_err    = d_rvalid & r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_last   <= PORT_D;
            r_port   <= PORT_C;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_c | w_pick_d) begin
                        r_port   <= w_pick_d ? PORT_D : PORT_C;
                        r_last   <= w_pick_d ? PORT_D : PORT_C;
                        r_we     <= w_pick_d ? d_we     : c_we;
                        r_funct3 <= w_pick_d ? d_funct3 : c_funct3;
                        r_addr   <= w_pick_d ? d_addr   : c_addr;
                        r_wdata  <= w_pick_d ? d_wdata  : c_wdata;
                        r_state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_rdata <= (~r_we & ~w_err) ? mem_rd_data : '0;
                    r_err   <= w_err;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, multi-cycle corner sequences and
// randomized single-port traffic checked against a byte-array reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [2:0]  c_funct3, d_funct3;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_wr_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    // Attached memory: little-endian bytes, combinational extended read, write on clk.
    logic [7:0] dut_mem [0:255] = '{default: 8'h00};
    logic [7:0] rb0, rb1, rb2, rb3;

    always_comb begin
        rb0 = dut_mem[mem_addr[7:0]];
        rb1 = dut_mem[mem_addr[7:0] + 8'd1];
        rb2 = dut_mem[mem_addr[7:0] + 8'd2];
        rb3 = dut_mem[mem_addr[7:0] + 8'd3];
        mem_rd_data = 32'h0;
        case (mem_funct3)
            3'b000:  mem_rd_data = {{24{rb0[7]}}, rb0};
            3'b001:  mem_rd_data = {{16{rb1[7]}}, rb1, rb0};
            3'b010:  mem_rd_data = {rb3, rb2, rb1, rb0};
            3'b100:  mem_rd_data = {24'h0, rb0};
            3'b101:  mem_rd_data = {16'h0, rb1, rb0};
            default: mem_rd_data = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            case (mem_funct3[1:0])
                2'b00: dut_mem[mem_addr[7:0]] <= mem_wr_data[7:0];
                2'b01: begin
                    dut_mem[mem_addr[7:0]]        <= mem_wr_data[7:0];
                    dut_mem[mem_addr[7:0] + 8'd1] <= mem_wr_data[15:8];
                end
                default: begin
                    dut_mem[mem_addr[7:0]]        <= mem_wr_data[7:0];
                    dut_mem[mem_addr[7:0] + 8'd1] <= mem_wr_data[15:8];
                    dut_mem[mem_addr[7:0] + 8'd2] <= mem_wr_data[23:16];
                    dut_mem[mem_addr[7:0] + 8'd3] <= mem_wr_data[31:24];
                end
            endcase
        end
    end

    // Reference model: plain byte array plus arithmetic rules for legality and extension.
    int ref_mem [256];

    function automatic int access_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        int size;
        size = access_size(f3);
        if (size == 0) return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        if ((addr % size) != 0) return 1'b1;
        if (addr >= 256) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        longint v;
        v = 0;
        for (int i = access_size(f3) - 1; i >= 0; i--) v = v * 256 + ref_mem[addr + i];
        if (f3 == 3'b000 && v >= 128)   v = v - 256;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        longint v;
        v = wd;
        for (int i = 0; i < access_size(f3); i++) begin
            ref_mem[addr + i] = int'(v % 256);
            v = v / 256;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input bit port, input bit we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        if (port) begin
            d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
        end else begin
            c_req = 1'b1; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wd;
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One single-requester transaction: grant at once, access next cycle, response after that.
    task automatic txn(input string tag, input bit port, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit e_err, input logic [31:0] e_rdata);
        int  n;
        bit  found;
        n = 0;
        found = 1'b0;
        @(posedge clk);
        #1;
        drive_req(port, we, f3, addr, wd);
        while (!found && n < 10) begin
            @(negedge clk);
            if (port ? d_gnt : c_gnt) found = 1'b1;
            else n++;
        end
        chk({tag, ".gnt_seen"}, 32'(found), 32'd1);
        chk({tag, ".gnt_latency"}, 32'(n), 32'd0);
        chk({tag, ".other_gnt"}, 32'(port ? c_gnt : d_gnt), 32'd0);
        @(posedge clk);
        #1;
        c_req = 1'b0;
        d_req = 1'b0;
        if (!found) return;
        @(negedge clk);
        chk({tag, ".mem_wr_en"}, 32'(mem_wr_en), 32'(we & ~e_err));
        chk({tag, ".mem_addr"}, mem_addr, addr);
        chk({tag, ".mem_funct3"}, 32'(mem_funct3), 32'(f3));
        chk({tag, ".early_rvalid"}, 32'(c_rvalid | d_rvalid), 32'd0);
        @(negedge clk);
        chk({tag, ".rvalid"}, 32'(port ? d_rvalid : c_rvalid), 32'd1);
        chk({tag, ".other_rvalid"}, 32'(port ? c_rvalid : d_rvalid), 32'd0);
        chk({tag, ".err"}, 32'(port ? d_err : c_err), 32'(e_err));
        chk({tag, ".rdata"}, port ? d_rdata : c_rdata, e_rdata);
        chk({tag, ".resp_wr_en"}, 32'(mem_wr_en), 32'd0);
        if (we && !e_err) model_store(f3, addr, wd);
    endtask

    typedef struct {
        string       name;
        bit          port;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int          nvec;
        int          gcyc [$];
        int          gport[$];
        int          wr_cnt;
        int          cyc;
        bit          p, we;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        bit          e;

        tbl[0]  = '{"sw_10",    1'b0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{"lw_10",    1'b0, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{"sb_13",    1'b1, 1'b1, 3'b000, 32'h13,  32'h00000080, 1'b0, 32'h0};
        tbl[3]  = '{"lb_13",    1'b0, 1'b0, 3'b000, 32'h13,  32'h0,        1'b0, 32'hFFFFFF80};
        tbl[4]  = '{"lbu_13",   1'b1, 1'b0, 3'b100, 32'h13,  32'h0,        1'b0, 32'h00000080};
        tbl[5]  = '{"lw_10b",   1'b0, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h80ADBEEF};
        tbl[6]  = '{"sh_21",    1'b1, 1'b1, 3'b001, 32'h21,  32'h0000BEEF, 1'b1, 32'h0};
        tbl[7]  = '{"lw_102",   1'b0, 1'b0, 3'b010, 32'h102, 32'h0,        1'b1, 32'h0};
        tbl[8]  = '{"f3_011",   1'b1, 1'b0, 3'b011, 32'h20,  32'h0,        1'b1, 32'h0};
        tbl[9]  = '{"lh_12",    1'b0, 1'b0, 3'b001, 32'h12,  32'h0,        1'b0, 32'hFFFF80AD};
        tbl[10] = '{"lhu_12",   1'b1, 1'b0, 3'b101, 32'h12,  32'h0,        1'b0, 32'h000080AD};
        tbl[11] = '{"sw_mis",   1'b0, 1'b1, 3'b010, 32'h1,   32'h11111111, 1'b1, 32'h0};
        tbl[12] = '{"st_f3_100",1'b1, 1'b1, 3'b100, 32'h24,  32'h22222222, 1'b1, 32'h0};
        tbl[13] = '{"sh_22",    1'b0, 1'b1, 3'b001, 32'h22,  32'h00001234, 1'b0, 32'h0};
        nvec = 14;

        for (int i = 0; i < 256; i++) ref_mem[i] = 0;
        c_req = 0; c_we = 0; c_funct3 = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;

        // Reset state, with both requests pending so a leaked grant would show.
        reset = 1'b1;
        c_req = 1'b1;
        d_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.c_gnt", 32'(c_gnt), 32'd0);
        chk("rst.d_gnt", 32'(d_gnt), 32'd0);
        chk("rst.rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
        chk("rst.rdata_err", c_rdata | d_rdata | 32'(c_err) | 32'(d_err), 32'd0);
        chk("rst.mem", mem_addr | mem_wr_data | 32'(mem_funct3) | 32'(mem_wr_en), 32'd0);
        c_req = 1'b0;
        d_req = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < nvec; i++)
            txn(tbl[i].name, tbl[i].port, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                tbl[i].e_err, tbl[i].e_rdata);
        txn("lw_20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h12340000);

        // Both ports requesting continuously after reset: C, D, C, D, three cycles apart.
        reset_pulse();
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b1, 3'b010, 32'h40, 32'hC0C0C0C0);
        drive_req(1'b1, 1'b1, 3'b010, 32'h44, 32'hD0D0D0D0);
        wr_cnt = 0;
        cyc = 0;
        while (gport.size() < 4 && cyc < 30) begin
            @(negedge clk);
            if (c_gnt && d_gnt) chk("rr.double_gnt", 32'd1, 32'd0);
            if (c_gnt) begin gport.push_back(0); gcyc.push_back(cyc); end
            if (d_gnt) begin gport.push_back(1); gcyc.push_back(cyc); end
            if (mem_wr_en) wr_cnt++;
            cyc++;
        end
        @(posedge clk);
        #1;
        c_req = 1'b0;
        d_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (mem_wr_en) wr_cnt++;
        end
        chk("rr.grant_count", 32'(gport.size()), 32'd4);
        for (int i = 0; i < gport.size(); i++) begin
            chk("rr.order", 32'(gport[i]), 32'(i % 2));
            if (i > 0) chk("rr.spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        chk("rr.write_count", 32'(wr_cnt), 32'd4);
        model_store(3'b010, 32'h40, 32'hC0C0C0C0);
        model_store(3'b010, 32'h44, 32'hD0D0D0D0);
        txn("rr.lw_40", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, model_load(3'b010, 32'h40));
        txn("rr.lw_44", 1'b0, 1'b0, 3'b010, 32'h44, 32'h0, 1'b0, model_load(3'b010, 32'h44));

        // D raises then drops its request while C is served; the next tie then goes to D.
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        chk("drop.c_gnt", 32'(c_gnt), 32'd1);
        @(posedge clk);
        #1;
        c_req = 1'b0;
        drive_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        @(negedge clk);
        chk("drop.d_gnt_access", 32'(d_gnt), 32'd0);
        @(negedge clk);
        chk("drop.d_gnt_resp", 32'(d_gnt), 32'd0);
        chk("drop.c_rvalid", 32'(c_rvalid), 32'd1);
        d_req = 1'b0;
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        drive_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        @(negedge clk);
        chk("drop.tie_d_gnt", 32'(d_gnt), 32'd1);
        chk("drop.tie_c_gnt", 32'(c_gnt), 32'd0);
        @(posedge clk);
        #1;
        c_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset arriving during the ACCESS cycle of a store aborts it.
        txn("rst.sw_30_old", 1'b0, 1'b1, 3'b010, 32'h30, 32'hAAAA5555, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b1, 3'b010, 32'h30, 32'h12345678);
        @(negedge clk);
        chk("rst.abort_gnt", 32'(c_gnt), 32'd1);
        @(posedge clk);
        #1;
        c_req = 1'b0;
        chk("rst.access_wr_en", 32'(mem_wr_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst.wr_en_drop", 32'(mem_wr_en), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst.no_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
        end
        txn("rst.lw_30", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'hAAAA5555);

        // Randomized single-port traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            p    = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(250, 300))
                                               : 32'($urandom_range(0, 63));
            wd   = $urandom;
            e    = model_err(we, f3, addr);
            txn("rand", p, we, f3, addr, wd, e, (we || e) ? 32'h0 : model_load(f3, addr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
